// File: rtl/ahb_rom_bridge.sv
// ahb_rom_bridge: AHB-Lite slave in front of a synchronous 32-bit memory.
// Define AHB_ROM_BRIDGE_WRITE_EN for buffered writes; without it every write gets a two-cycle ERROR.
module ahb_rom_bridge #(
   parameter int AW = 14
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          HSEL,
   input  logic [AW-1:0] HADDR,
   input  logic [1:0]    HTRANS,
   input  logic [2:0]    HSIZE,
   input  logic          HWRITE,
   input  logic [31:0]   HWDATA,
   input  logic          HREADY,
   output logic          HREADYOUT,
   output logic          HRESP,
   output logic [31:0]   HRDATA,
   input  logic [31:0]   SRAMRDATA,
   output logic [AW-3:0] SRAMADDR,
   output logic [31:0]   SRAMWDATA,
   output logic [3:0]    SRAMWEN,
   output logic          SRAMCS
);
   logic          acc, rd_acc, wr_acc, rd_phase;
   logic [AW-3:0] rd_addr;
   logic [31:0]   rd_word;
   // Gating with HRESETn keeps the memory port quiet while reset is held.
   assign acc    = HSEL & HREADY & HTRANS[1] & HRESETn;
   assign rd_acc = acc & ~HWRITE;
   assign wr_acc = acc & HWRITE;
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         rd_phase <= 1'b0;
         rd_addr  <= '0;
      end else begin
         rd_phase <= rd_acc;
         if (rd_acc) rd_addr <= HADDR[AW-1:2];
      end
   assign HRDATA = rd_phase ? rd_word : 32'h0;
`ifdef AHB_ROM_BRIDGE_WRITE_EN
   logic          wr_phase, buf_pend, drain, hit, unused;
   logic [AW-3:0] wr_addr, buf_addr;
   logic [3:0]    wr_mask, buf_mask, mask;
   logic [31:0]   buf_data;
   assign unused = HTRANS[0];
   always_comb
      mask = HSIZE == 3'b000 ? 4'b0001 << HADDR[1:0] :
             HSIZE == 3'b001 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   // A read owns the port; the buffered write waits for the next free cycle.
   assign drain = buf_pend & ~rd_acc;
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         wr_phase <= 1'b0;
         wr_addr  <= '0;
         wr_mask  <= '0;
         buf_pend <= 1'b0;
         buf_addr <= '0;
         buf_mask <= '0;
         buf_data <= '0;
      end else begin
         wr_phase <= wr_acc;
         if (wr_acc) begin
            wr_addr <= HADDR[AW-1:2];
            wr_mask <= mask;
         end
         if (wr_phase) begin
            buf_pend <= 1'b1;
            buf_addr <= wr_addr;
            buf_mask <= wr_mask;
            buf_data <= HWDATA;
         end else if (drain) buf_pend <= 1'b0;
      end
   assign hit = buf_pend & (rd_addr == buf_addr);
   always_comb begin
      rd_word = SRAMRDATA;
      for (int i = 0; i < 4; i++)
         if (hit && buf_mask[i]) rd_word[8*i +: 8] = buf_data[8*i +: 8];
   end
   assign SRAMCS    = rd_acc | drain;
   assign SRAMADDR  = rd_acc ? HADDR[AW-1:2] : buf_addr;
   assign SRAMWEN   = drain ? buf_mask : 4'b0000;
   assign SRAMWDATA = buf_data;
   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
`else
   typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;
   state_t state, state_nx;
   logic   unused;
   assign unused = ^{HTRANS[0], HSIZE, HWDATA, HADDR[1:0]};
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) state <= IDLE;
      else state <= state_nx;
   always_comb state_nx = state == ERR1 ? ERR2 : wr_acc ? ERR1 : IDLE;
   always_comb begin
      HREADYOUT = state != ERR1;
      HRESP     = state != IDLE;
   end
   assign rd_word   = SRAMRDATA;
   assign SRAMCS    = rd_acc;
   assign SRAMADDR  = HADDR[AW-1:2];
   assign SRAMWEN   = 4'b0000;
   assign SRAMWDATA = 32'h0;
`endif
endmodule

// File: tb/tb_ahb_rom_bridge.sv
// tb_ahb_rom_bridge: random AHB traffic against a word-level golden memory, plus directed scenarios.
// Covers both builds selected by AHB_ROM_BRIDGE_WRITE_EN.
module tb_ahb_rom_bridge;
   localparam int AW = 14;
   localparam int NW = 1 << (AW - 2);
   logic          HCLK = 1'b0, HRESETn = 1'b0;
   logic          hsel = 1'b0, hwrite = 1'b0, rdy_en = 1'b1, hready;
   logic [AW-1:0] haddr = '0;
   logic [1:0]    htrans = '0;
   logic [2:0]    hsize = '0;
   logic [31:0]   hwdata = '0, sram_q = '0;
   logic          hreadyout, hresp, sramcs;
   logic [31:0]   hrdata, sramwdata;
   logic [AW-3:0] sramaddr;
   logic [3:0]    sramwen;
   logic [31:0]   mem [NW];
   logic [31:0]   gold [NW];
   int            checks = 0, errors = 0;
   int            a1 = 0, a2 = 0, err_left = 0, wr_word = 0, wr_lo = 0, wr_n = 0;
   logic          rd_q = 1'b0, wr_q = 1'b0, m_acc;
   logic [31:0]   rd_exp = '0;

   assign hready = hreadyout & rdy_en;

   ahb_rom_bridge #(.AW(AW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
      .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
      .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata), .SRAMRDATA(sram_q),
      .SRAMADDR(sramaddr), .SRAMWDATA(sramwdata), .SRAMWEN(sramwen), .SRAMCS(sramcs)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask

   // Memory behind the bridge: one-cycle read latency, byte-enabled writes.
   always @(posedge HCLK)
      if (sramcs) begin
         if (|sramwen) begin
            for (int b = 0; b < 4; b++)
               if (sramwen[b]) mem[sramaddr][8*b +: 8] <= sramwdata[8*b +: 8];
         end else sram_q <= mem[sramaddr];
      end

   // Bus-level model: writes land in gold when their data phase completes,
   // a read returns gold as seen after every earlier transfer.
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         chk("rst_hreadyout", 32'(hreadyout), 1);
         chk("rst_hresp", 32'(hresp), 0);
         chk("rst_hrdata", hrdata, 0);
         chk("rst_sramcs", 32'(sramcs), 0);
         chk("rst_sramwen", 32'(sramwen), 0);
         rd_q = 1'b0;
         wr_q = 1'b0;
         err_left = 0;
         a1 = 0;
         a2 = 0;
      end else begin
`ifdef AHB_ROM_BRIDGE_WRITE_EN
         if (wr_q)
            for (int b = wr_lo; b < wr_lo + wr_n; b++) gold[wr_word][8*b +: 8] = hwdata[8*b +: 8];
         chk("hreadyout", 32'(hreadyout), 1);
         chk("hresp", 32'(hresp), 0);
`else
         chk("hreadyout", 32'(hreadyout), err_left == 2 ? 0 : 1);
         chk("hresp", 32'(hresp), err_left != 0 ? 1 : 0);
         chk("sramwen_never", 32'(sramwen), 0);
         if (err_left > 0) err_left--;
`endif
         chk("hrdata", hrdata, rd_q ? rd_exp : 32'h0);
         m_acc = hsel & hready & htrans[1];
         rd_q = m_acc & ~hwrite;
         wr_q = m_acc & hwrite;
         if (rd_q) begin
            chk("rd_sramcs", 32'(sramcs), 1);
            chk("rd_sramaddr", 32'(sramaddr), 32'(haddr >> 2));
            chk("rd_sramwen", 32'(sramwen), 0);
            rd_exp = gold[haddr >> 2];
         end
         if (wr_q) begin
            wr_word = int'(haddr >> 2);
            wr_n = 1 << (hsize > 3'd2 ? 2 : int'(hsize));
            wr_lo = int'(haddr[1:0]) & ~(wr_n - 1);
`ifndef AHB_ROM_BRIDGE_WRITE_EN
            err_left = 2;
`endif
         end
         a2 = a1;
         a1 = !m_acc ? 0 : hwrite ? 2 : 1;
      end
   end

   task automatic bus(input logic s, input logic [1:0] t, input logic w, input logic [AW-1:0] a,
                      input logic [2:0] z, input logic [31:0] d);
      @(posedge HCLK);
      #1;
      hsel = s; htrans = t; hwrite = w; haddr = a; hsize = z; hwdata = d;
      @(negedge HCLK);
   endtask

   initial begin
      int w, z, off;
      for (int i = 0; i < NW; i++) begin
         mem[i] = 32'h9E3779B9 * (i + 1);
         gold[i] = 32'h9E3779B9 * (i + 1);
      end
      mem[4] = 32'hDEADBEEF;  gold[4] = 32'hDEADBEEF;
      mem[8] = 32'h11223344;  gold[8] = 32'h11223344;
      hsel = 1'b1; htrans = 2'b10; haddr = 'h10;
      repeat (2) @(negedge HCLK);
      chk("rst_read_blocked", 32'(sramcs), 0);
      chk("rst_ready_lit", 32'(hreadyout), 1);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1; hsel = 1'b0; htrans = 2'b00;
      bus(1, 2'b10, 0, 'h10, 3'b010, 0);
      chk("r37_cs", 32'(sramcs), 1);
      chk("r37_addr", 32'(sramaddr), 4);
      bus(0, 0, 0, 0, 0, 0);
      chk("r37_data", hrdata, 32'hDEADBEEF);
      chk("r37_ready", 32'(hreadyout), 1);
`ifdef AHB_ROM_BRIDGE_WRITE_EN
      bus(1, 2'b10, 1, 'h21, 3'b000, 0);
      bus(1, 2'b10, 0, 'h20, 3'b010, 32'hABABABAB);
      chk("r39_rd_cs", 32'(sramcs), 1);
      chk("r39_rd_wen", 32'(sramwen), 0);
      chk("r39_rd_addr", 32'(sramaddr), 8);
      bus(0, 0, 0, 0, 0, 0);
      chk("r39_merge", hrdata, 32'h1122AB44);
      chk("r39_drain_wen", 32'(sramwen), 32'b0010);
      chk("r39_drain_addr", 32'(sramaddr), 8);
      bus(0, 0, 0, 0, 0, 0);
      chk("r39_single", 32'(sramwen), 0);
      bus(1, 2'b10, 1, 'h20, 3'b010, 0);
      bus(0, 0, 0, 0, 0, 32'h12345678);
      chk("r38_no_early", 32'(sramwen), 0);
      bus(0, 0, 0, 0, 0, 0);
      chk("r38_cs", 32'(sramcs), 1);
      chk("r38_wen", 32'(sramwen), 32'hF);
      chk("r38_addr", 32'(sramaddr), 8);
      chk("r38_wdata", sramwdata, 32'h12345678);
      bus(1, 2'b10, 1, 'h42, 3'b001, 0);
      bus(1, 2'b10, 0, 'h100, 3'b010, 32'hCAFE0000);
      chk("r40_rd0_wen", 32'(sramwen), 0);
      repeat (4) begin
         bus(1, 2'b11, 0, 'h100, 3'b010, 0);
         chk("r40_rd_wen", 32'(sramwen), 0);
      end
      bus(0, 0, 0, 0, 0, 0);
      chk("r40_wen", 32'(sramwen), 32'b1100);
      chk("r40_addr", 32'(sramaddr), 'h10);
      chk("r40_wdata", 32'(sramwdata[31:16]), 32'hCAFE);
      bus(0, 0, 0, 0, 0, 0);
      chk("r40_single", 32'(sramwen), 0);
      bus(1, 2'b10, 1, 'h30, 3'b010, 0);
      @(posedge HCLK);
      #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'h55AA55AA; HRESETn = 1'b0;
      @(negedge HCLK);
      chk("r41_hrdata", hrdata, 0);
      chk("r41_wen", 32'(sramwen), 0);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      repeat (3) begin
         bus(0, 0, 0, 0, 0, 0);
         chk("r41_no_write", 32'(sramwen), 0);
      end
      chk("r41_mem", mem[12], gold[12]);
`else
      bus(1, 2'b10, 1, 'h4, 3'b010, 0);
      chk("r42_addr_ready", 32'(hreadyout), 1);
      chk("r42_addr_resp", 32'(hresp), 0);
      bus(0, 0, 0, 0, 0, 32'h11111111);
      chk("r42_err1_ready", 32'(hreadyout), 0);
      chk("r42_err1_resp", 32'(hresp), 1);
      bus(0, 0, 0, 0, 0, 0);
      chk("r42_err2_ready", 32'(hreadyout), 1);
      chk("r42_err2_resp", 32'(hresp), 1);
      bus(0, 0, 0, 0, 0, 0);
      chk("r42_idle_ready", 32'(hreadyout), 1);
      chk("r42_idle_resp", 32'(hresp), 0);
`endif
      repeat (3000) begin
         @(posedge HCLK);
         #1;
         w = $urandom_range(0, 9);
         if (w > 7) w = NW - 10 + w;
         z = $urandom_range(0, 2);
         off = $urandom_range(0, 3) & ~((1 << z) - 1);
         hsel = $urandom_range(0, 3) != 0;
         htrans = 2'($urandom_range(0, 3));
         hwrite = $urandom_range(0, 1) != 0;
         haddr = AW'(w * 4 + off);
         hsize = 3'(z);
         hwdata = $urandom;
         rdy_en = (a1 == 0 && err_left == 0) ? $urandom_range(0, 7) != 0 : 1'b1;
`ifdef AHB_ROM_BRIDGE_WRITE_EN
         if (a1 == 2 && a2 == 2) hwrite = 1'b1;
`endif
      end
      rdy_en = 1'b1;
      repeat (6) bus(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) chk("final_mem", mem[i], gold[i]);
      chk("final_mem_top0", mem[NW-2], gold[NW-2]);
      chk("final_mem_top1", mem[NW-1], gold[NW-1]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
